// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default word width and the divide-by-zero quotient fill value.
package div_pkg;

   localparam int WORD_W_DEF = 32;

   // Every quotient bit is set to this value on a divide by zero
   localparam logic DIV0_QUOT_FILL = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_restoring_step.sv
// One radix-2 restoring iteration: shift {rem, quot} left, trial-subtract
// the divisor and keep the difference when it does not borrow.
module div_restoring_step #(
   parameter int OP_W = 64
) (
   input  logic [OP_W:0]   rem,
   input  logic [OP_W-1:0] quot,
   input  logic [OP_W-1:0] divisor,
   output logic [OP_W:0]   rem_next,
   output logic [OP_W-1:0] quot_next
);

   logic [OP_W+1:0] rem_sh;
   logic [OP_W+1:0] trial;

   // rem < divisor on entry, so rem_sh[OP_W+1] is always 0 and trial's MSB is the borrow
   always_comb begin
      rem_sh = {rem, quot[OP_W-1]};
      trial  = rem_sh - {2'b00, divisor};
      if (trial[OP_W+1]) begin
         rem_next  = rem_sh[OP_W:0];
         quot_next = {quot[OP_W-2:0], 1'b0};
      end else begin
         rem_next  = trial[OP_W:0];
         quot_next = {quot[OP_W-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/div64x64_multiciclo.sv
// Sequential unsigned 64/64 divider, one quotient bit per clock, with a
// start/busy/done handshake and word-split operands and results.
//
//  state | meaning
//  IDLE  | waiting for start; results from the last operation held
//  RUN   | one restoring iteration per clock, counter running down
//  DONE  | publish working registers to the outputs, pulse done
module div64x64_multiciclo
   import div_pkg::*;
#(
   parameter  int WORD_W = WORD_W_DEF,
   localparam int ITER   = 2 * WORD_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [WORD_W-1:0] a_hi,
   input  logic [WORD_W-1:0] a_low,
   input  logic [WORD_W-1:0] b_hi,
   input  logic [WORD_W-1:0] b_low,
   output logic              busy,
   output logic              done,
   output logic              div_by_zero,
   output logic [WORD_W-1:0] quot_hi,
   output logic [WORD_W-1:0] quot_low,
   output logic [WORD_W-1:0] rem_hi,
   output logic [WORD_W-1:0] rem_low
);

   localparam int OP_W  = 2 * WORD_W;
   localparam int CNT_W = $clog2(ITER + 1);

   div_state_t        state;
   logic [OP_W:0]     rem_w;
   logic [OP_W-1:0]   quot_w;
   logic [OP_W-1:0]   div_w;
   logic [CNT_W-1:0]  cnt;
   logic              dz_w;
   logic [OP_W:0]     rem_nx;
   logic [OP_W-1:0]   quot_nx;

   div_restoring_step #(.OP_W(OP_W)) u_step (
      .rem       (rem_w),
      .quot      (quot_w),
      .divisor   (div_w),
      .rem_next  (rem_nx),
      .quot_next (quot_nx)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         quot_hi     <= '0;
         quot_low    <= '0;
         rem_hi      <= '0;
         rem_low     <= '0;
         rem_w       <= '0;
         quot_w      <= '0;
         div_w       <= '0;
         cnt         <= '0;
         dz_w        <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  div_w <= {b_hi, b_low};
                  if ({b_hi, b_low} == '0) begin
                     quot_w <= {OP_W{DIV0_QUOT_FILL}};
                     rem_w  <= {1'b0, a_hi, a_low};
                     dz_w   <= 1'b1;
                     state  <= DONE;
                  end else begin
                     quot_w <= {a_hi, a_low};
                     rem_w  <= '0;
                     dz_w   <= 1'b0;
                     cnt    <= CNT_W'(ITER);
                     busy   <= 1'b1;
                     state  <= RUN;
                  end
               end
            end
            RUN: begin
               rem_w  <= rem_nx;
               quot_w <= quot_nx;
               cnt    <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  busy  <= 1'b0;
                  state <= DONE;
               end
            end
            DONE: begin
               done        <= 1'b1;
               div_by_zero <= dz_w;
               quot_hi     <= quot_w[OP_W-1:WORD_W];
               quot_low    <= quot_w[WORD_W-1:0];
               rem_hi      <= rem_w[OP_W-1:WORD_W];
               rem_low     <= rem_w[WORD_W-1:0];
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div64x64_multiciclo.sv
// Scoreboard bench for the sequential divider: expected results are queued
// at start and compared whenever done pulses.
module tb_div64x64_multiciclo;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] a_hi = '0, a_low = '0, b_hi = '0, b_low = '0;
   logic        busy, done, div_by_zero;
   logic [31:0] quot_hi, quot_low, rem_hi, rem_low;

   typedef struct packed {
      logic [63:0] q;
      logic [63:0] r;
      logic        dz;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;

   div64x64_multiciclo dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .a_hi        (a_hi),
      .a_low       (a_low),
      .b_hi        (b_hi),
      .b_low       (b_low),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .quot_hi     (quot_hi),
      .quot_low    (quot_low),
      .rem_hi      (rem_hi),
      .rem_low     (rem_low)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("quot", {quot_hi, quot_low}, mon_e.q);
            chk("rem", {rem_hi, rem_low}, mon_e.r);
            chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, mon_e.dz});
         end
      end
   end

   // poke >= 0 drives an ignored start with other operands at that RUN cycle
   task automatic do_div(input logic [63:0] a, input logic [63:0] b,
                         input int exp_lat, input int poke);
      exp_t e;
      int   n;
      e.dz = (b == 64'd0);
      e.q  = e.dz ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
      e.r  = e.dz ? a : a % b;
      @(negedge clk);
      {a_hi, a_low} = a;
      {b_hi, b_low} = b;
      start = 1'b1;
      sb.push_back(e);
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      while (n < 200) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (done) break;
         if (n == 5) chk("busy_run", {63'd0, busy}, 64'd1);
         if (poke >= 0 && n == poke) begin
            {a_hi, a_low} = 64'd50;
            {b_hi, b_low} = 64'd5;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (poke >= 0 && n == poke + 1) chk("busy_after_poke", {63'd0, busy}, 64'd1);
      end
      chk("latency", 64'(n), 64'(exp_lat));
      chk("busy_at_done", {63'd0, busy}, 64'd0);
      repeat (3) @(negedge clk);
      chk("hold_quot", {quot_hi, quot_low}, e.q);
      chk("hold_rem", {rem_hi, rem_low}, e.r);
      chk("done_pulse", {63'd0, done}, 64'd0);
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_outs"}, {quot_hi, quot_low} | {rem_hi, rem_low}, 64'd0);
      chk({tag, "_flags"}, {61'd0, busy, done, div_by_zero}, 64'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_cleared("reset");
      rst_n = 1'b1;

      do_div(64'd100, 64'd7, 65, -1);
      do_div(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 65, -1);
      do_div(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65, -1);
      do_div(64'd5, 64'h1_0000_0000, 65, -1);
      do_div(64'h1234_5678_9ABC_DEF0, 64'd0, 1, -1);
      do_div(64'd200, 64'd9, 65, -1);
      do_div(64'd100, 64'd7, 65, 10);

      // abort an operation with a one-edge reset at RUN cycle 30
      @(negedge clk);
      {a_hi, a_low} = 64'hDEAD_BEEF_0000_1234;
      {b_hi, b_low} = 64'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (29) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk_cleared("abort");
      repeat (80) @(negedge clk);
      chk("abort_idle_busy", {63'd0, busy}, 64'd0);

      do_div(64'h1_0000_0000, 64'h1_0000, 65, -1);

      for (int i = 0; i < 4; i++) begin
         do_div({$urandom, $urandom}, {32'd0, $urandom | 32'd1} >> (i * 7), 65, -1);
      end

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/div64x64_multiciclo.md
Name: div64x64_multiciclo

Overview:
Sequential unsigned 64/64 integer divider, the inverse of the single-cycle 64x64 multiplier in the same arithmetic datapath. Operands and results are carried as 32-bit hi/low word pairs to match the multiplier's word-oriented interface. Radix-2 restoring algorithm, one quotient bit per clock, with a start/busy/done handshake. Intended for throughput-insensitive paths where a single-cycle divider would not close timing.

Parameters:
WORD_W, 32, width of each operand/result word; full operand width is 2*WORD_W.
ITER, 2*WORD_W, number of restoring iterations; fixed to the full operand width and not to be overridden.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous reset, active-low
start  input  1  request a divide; sampled only in IDLE
a_hi  input  WORD_W  dividend most significant word
a_low  input  WORD_W  dividend least significant word
b_hi  input  WORD_W  divisor most significant word
b_low  input  WORD_W  divisor least significant word
busy  output  1  high while an operation is in progress (RUN)
done  output  1  one-cycle pulse; results are valid from this cycle onward
div_by_zero  output  1  set with done when divisor == 0
quot_hi  output  WORD_W  quotient most significant word
quot_low  output  WORD_W  quotient least significant word
rem_hi  output  WORD_W  remainder most significant word
rem_low  output  WORD_W  remainder least significant word

Behaviour:
- One clock, synchronous active-low reset: rst_n=0 at a rising edge drives state to IDLE and every output (busy, done, div_by_zero, quot_*, rem_*) to 0.
- Reset mid-operation aborts the operation with no partial result exposed. The first start accepted after reset is a fresh operation.
- FSM states: IDLE, RUN, DONE.
- IDLE with start=1 and divisor != 0:
  - Latch {a_hi,a_low} into the quotient/shift register and {b_hi,b_low} into the divisor register.
  - Clear the partial remainder (2*WORD_W+1 bits) and load the iteration counter with ITER.
  - Go to RUN and assert busy next cycle.
- IDLE with start=1 and divisor == 0:
  - Go directly to DONE.
  - Outputs: quot = all ones, rem = dividend, div_by_zero=1.
- RUN, each cycle:
  - Shift {rem, quot} left by 1.
  - trial = rem - divisor. If trial is non-negative, rem = trial and quot LSB = 1; otherwise quot LSB = 0.
  - Decrement the counter. After the cycle that takes the counter to 0, go to DONE.
- DONE (one cycle):
  - done=1, busy=0.
  - quot_*/rem_* outputs are registered from the working registers; div_by_zero=0 unless set by the zero path.
  - Return to IDLE next cycle.
- Latency: start sampled at edge t; normal path gives done=1 in the cycle after edge t+65; the zero path gives done one cycle after the start edge.
- Result outputs and div_by_zero hold their values after done until the next accepted start overwrites them at its DONE.
- start while busy or in DONE is ignored. It is not queued.
- Operands are sampled only at the accepted start edge; input changes during RUN have no effect.
- All arithmetic is unsigned. Remainder < divisor is guaranteed for divisor != 0.

Decomposition:
- Shared package (div_pkg): FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), the WORD_W default, and the divide-by-zero quotient constant (all ones).
- One combinational sub-module, div_restoring_step. Inputs: partial remainder, quotient, divisor. Outputs: next remainder and next quotient. Instantiated once by the top-level FSM/counter; this allows later unrolling to radix-4.

Test Plan:
- a=0x0_00000064 (100), b=0x0_00000007, pulse start → done exactly 65 cycles after the start edge; quot=14 (hi=0, low=0xE); rem=2; div_by_zero=0.
- a=0xFFFFFFFF_FFFFFFFF, b=0x00000000_00000001 → quot=0xFFFFFFFF_FFFFFFFF, rem=0. Repeat with b=a → quot=1, rem=0.
- a=0x00000000_00000005, b=0x00000001_00000000 (dividend < divisor) → quot=0, rem=5, done after 65 cycles.
- b=0 with a=0x12345678_9ABCDEF0 → done one cycle after start; div_by_zero=1; quot=all ones; rem=0x12345678_9ABCDEF0. A following normal divide clears div_by_zero.
- Start 100/7, then pulse start with a=50, b=5 at cycle 10 of RUN → ignored; result remains q=14, r=2; busy stays high until done.
- Start a divide, drive rst_n=0 at cycle 30 for one edge → all outputs 0, state IDLE, no done pulse. Then 0x1_00000000 / 0x10000 → quot=0x10000, rem=0.
